// File: rtl/temp_pkg.sv
// Shared types and defaults for the temperature alarm stage.
// Thresholds are in raw ADC counts.
package temp_pkg;

    localparam int unsigned ADC_W        = 10;
    localparam int unsigned AVG_LOG2_DEF = 2;
    localparam int unsigned TH_HI_DEF    = 37;
    localparam int unsigned HYST_DEF     = 2;
    localparam int unsigned CONFIRM_DEF  = 3;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic [1:0] {
        COOL    = 2'd0,
        TO_HOT  = 2'd1,
        HOT     = 2'd2,
        TO_COOL = 2'd3
    } state_t;

    localparam logic [1:0] LED_HOT  = 2'b01;
    localparam logic [1:0] LED_COOL = 2'b10;

    // Pending states keep the indication of the state they may leave.
    function automatic logic is_hot_state(input state_t s);
        return (s == HOT) || (s == TO_COOL);
    endfunction

endpackage

// File: rtl/temp_avg.sv
// Block averager: sums 2^AVG_LOG2 accepted samples and emits their truncated
// mean with a one-cycle strobe.
module temp_avg
    import temp_pkg::*;
#(
    parameter int unsigned W        = ADC_W,
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic         clk,
    input  logic         rstc,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    output logic [W-1:0] avg_out,
    output logic         avg_valid
);

    localparam int unsigned ACC_W   = W + AVG_LOG2;
    localparam int unsigned SCNT_W  = AVG_LOG2 + 1;
    localparam int unsigned LAST    = (1 << AVG_LOG2) - 1;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  sum;
    logic [SCNT_W-1:0] scnt_q;
    logic [W-1:0]      avg_q;
    logic              avg_valid_q;

    // Partial sum never exceeds (2^AVG_LOG2)*(2^W-1), so ACC_W bits suffice.
    assign sum = acc_q + ACC_W'(sample_in);

    always_ff @(posedge clk) begin
        if (rstc) begin
            acc_q       <= '0;
            scnt_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (sample_valid) begin
                if (scnt_q == SCNT_W'(LAST)) begin
                    avg_q       <= W'(sum >> AVG_LOG2);
                    avg_valid_q <= 1'b1;
                    acc_q       <= '0;
                    scnt_q      <= '0;
                end else begin
                    acc_q  <= sum;
                    scnt_q <= scnt_q + SCNT_W'(1);
                end
            end
        end
    end

    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/temp_alarm.sv
// Debounced HOT/COOL classifier on block-averaged ADC samples, driving the
// board status LEDs and the alarm flag.
module temp_alarm
    import temp_pkg::*;
#(
    parameter int unsigned W        = ADC_W,
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
    parameter int unsigned TH_HI    = TH_HI_DEF,
    parameter int unsigned HYST     = HYST_DEF,
    parameter int unsigned CONFIRM  = CONFIRM_DEF
) (
    input  logic         clk,
    input  logic         rstc,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    output logic [W-1:0] avg_out,
    output logic         avg_valid,
    output logic [1:0]   led,
    output logic         alarm,
    output logic [1:0]   state_o
);

    localparam logic [W-1:0]     HOT_LIM  = W'(TH_HI);
    localparam logic [W-1:0]     COOL_LIM = W'(TH_HI - HYST);
    localparam logic [CNT_W-1:0] CONF_N   = CNT_W'(CONFIRM);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [1:0]        led_q, led_d;
    logic              alarm_q, alarm_d;
    logic              hot_ev;
    logic              cool_ev;

    temp_avg #(
        .W        (W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk          (clk),
        .rstc         (rstc),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid)
    );

    // Strict compares: averages on either band edge are neutral.
    assign hot_ev  = avg_out > HOT_LIM;
    assign cool_ev = avg_out < COOL_LIM;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rstc) begin
            state_q <= COOL;
            cnt_q   <= '0;
            led_q   <= LED_COOL;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        alarm_d = alarm_q;

        if (avg_valid) begin
            case (state_q)
                COOL: begin
                    if (hot_ev) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (CONFIRM == 1) ? HOT : TO_HOT;
                    end else begin
                        cnt_d = '0;
                    end
                end
                TO_HOT: begin
                    if (hot_ev) begin
                        if (cnt_inc == CONF_N) begin
                            state_d = HOT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = COOL;
                        cnt_d   = '0;
                    end
                end
                HOT: begin
                    if (cool_ev) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (CONFIRM == 1) ? COOL : TO_COOL;
                    end
                end
                TO_COOL: begin
                    if (cool_ev) begin
                        if (cnt_inc == CONF_N) begin
                            state_d = COOL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = HOT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = COOL;
                    cnt_d   = '0;
                end
            endcase

            led_d   = is_hot_state(state_d) ? LED_HOT : LED_COOL;
            alarm_d = is_hot_state(state_d);
        end
    end

    assign led     = led_q;
    assign alarm   = alarm_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_temp_alarm.sv
// Self-checking bench for temp_alarm: directed scenarios with literal
// expectations plus randomized traffic against a block/streak reference model.
module tb_temp_alarm;

    localparam int unsigned W       = 10;
    localparam int unsigned NAVG    = 4;
    localparam int unsigned TH_HI   = 37;
    localparam int unsigned HYST    = 2;
    localparam int unsigned CONFIRM = 3;

    logic         clk = 1'b0;
    logic         rstc = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic         sample_valid = 1'b0;
    logic [W-1:0] avg_out;
    logic         avg_valid;
    logic [1:0]   led;
    logic         alarm;
    logic [1:0]   state_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    temp_alarm dut (
        .clk          (clk),
        .rstc         (rstc),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .led          (led),
        .alarm        (alarm),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Reference model: running block, then "hot" flag plus streak of opposing evidence.
    int unsigned blk_sum = 0;
    int unsigned blk_n   = 0;
    int unsigned m_avg   = 0;
    bit          m_avg_valid = 1'b0;
    bit          m_hot   = 1'b0;
    int unsigned streak  = 0;

    function automatic int unsigned m_state();
        if (m_hot) return (streak != 0) ? 3 : 2;
        return (streak != 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (rstc) begin
            blk_sum = 0; blk_n = 0; m_avg = 0; m_avg_valid = 1'b0;
            m_hot = 1'b0; streak = 0;
        end else begin
            if (m_avg_valid) begin
                bit evid;
                evid = m_hot ? (m_avg < TH_HI - HYST) : (m_avg > TH_HI);
                streak = evid ? streak + 1 : 0;
                if (streak == CONFIRM) begin
                    m_hot  = !m_hot;
                    streak = 0;
                end
            end
            m_avg_valid = 1'b0;
            if (sample_valid) begin
                blk_sum += int'(sample_in);
                blk_n++;
                if (blk_n == NAVG) begin
                    m_avg       = blk_sum / NAVG;
                    m_avg_valid = 1'b1;
                    blk_sum     = 0;
                    blk_n       = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("avg_valid", int'(avg_valid), int'(m_avg_valid));
            chk("avg_out",   int'(avg_out),   m_avg);
            chk("led",       int'(led),       m_hot ? 1 : 2);
            chk("alarm",     int'(alarm),     int'(m_hot));
            chk("state_o",   int'(state_o),   m_state());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstc = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstc = 1'b0;
    endtask

    task automatic send(input int unsigned v, input int gap);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in = W'(v);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Four equal samples back to back; returns once led reflects the average.
    task automatic block4(input int unsigned v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in = W'(v);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seq[5];
        int av[5];
        seq = '{1, 1, 0, 1, 1};
        av  = '{40, 40, 37, 40, 40};

        // Reset state
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_led", int'(led), 2);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_avg_out", int'(avg_out), 0);
        chk("rst_state", int'(state_o), 0);

        // 36,38,40,42 with gaps -> 39
        send(36, 1); send(38, 1); send(40, 1);
        @(negedge clk);
        sample_valid = 1'b1; sample_in = W'(42);
        @(negedge clk);
        sample_valid = 1'b0;
        chk("blk_avg_valid", int'(avg_valid), 1);
        chk("blk_avg_out", int'(avg_out), 39);
        chk("mdl_avg_out", m_avg, 39);
        chk("blk_state_pre", int'(state_o), 0);
        @(negedge clk);
        chk("blk_state_post", int'(state_o), 1);
        chk("blk_valid_pulse", int'(avg_valid), 0);

        // Three hot blocks from COOL
        do_reset();
        block4(40); chk("hot1_led", int'(led), 2);
        block4(40); chk("hot2_led", int'(led), 2);
        block4(40); chk("hot3_led", int'(led), 1);
        chk("hot3_alarm", int'(alarm), 1);
        chk("mdl_hot3", int'(m_hot), 1);

        // Band edge 35 keeps HOT, then 34 cools down
        for (int i = 0; i < 3; i++) begin
            block4(35);
            chk("edge35_state", int'(state_o), 2);
        end
        block4(34); chk("cool1_state", int'(state_o), 3);
        chk("cool1_led", int'(led), 1);
        block4(34); chk("cool2_state", int'(state_o), 3);
        block4(34); chk("cool3_led", int'(led), 2);
        chk("cool3_alarm", int'(alarm), 0);

        // Edge 37 breaks a pending rise
        do_reset();
        for (int i = 0; i < 5; i++) begin
            block4(av[i]);
            chk("brk_state", int'(state_o), seq[i]);
            chk("mdl_brk_state", m_state(), seq[i]);
        end

        // Reset mid-block discards partial sum; valid during reset ignored
        do_reset();
        send(500, 0); send(500, 0);
        @(negedge clk);
        rstc = 1'b1; sample_valid = 1'b1; sample_in = W'(500);
        @(negedge clk);
        rstc = 1'b0; sample_valid = 1'b0;
        send(100, 0); send(100, 0); send(100, 0); send(100, 0);
        chk("discard_valid", int'(avg_valid), 1);
        chk("discard_avg", int'(avg_out), 100);

        // Randomized traffic around the band
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rstc = ($urandom_range(0, 499) == 0);
            sample_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) sample_in = W'($urandom_range(0, 1023));
            else sample_in = W'($urandom_range(31, 43));
        end
        @(negedge clk);
        rstc = 1'b0; sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/temp_alarm.md
Name: temp_alarm

Overview:
- Downstream consumer of the serial temperature ADC front end.
- Takes each completed 10-bit conversion word with a one-cycle valid strobe.
- Block-averages 2^AVG_LOG2 samples, then classifies the average as HOT or COOL using a hysteresis band and a consecutive-confirmation counter.
- Drives the two board status LEDs and a registered alarm flag. Replaces the ad-hoc threshold compare with a debounced, fully synchronous stage.

Parameters:
- W, 10, ADC sample width.
- AVG_LOG2, 2, log2 of samples per average (4); legal 0..4.
- TH_HI, 37, average strictly above this counts as hot evidence.
- HYST, 2, average strictly below TH_HI-HYST counts as cool evidence; HYST < TH_HI required.
- CONFIRM, 3, consecutive evidence averages needed to change state; legal 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstc  input  1  synchronous active-high reset.
- sample_in  input  W  ADC conversion result.
- sample_valid  input  1  one-cycle strobe; sample_in is accepted on the edge where this is high.
- avg_out  output  W  most recent block average.
- avg_valid  output  1  one-cycle strobe when avg_out updates.
- led  output  2  led[0]=hot indicator, led[1]=cool indicator; exactly one bit high.
- alarm  output  1  high while classified HOT.
- state_o  output  2  current FSM state for debug.

Behaviour:
- Interface: one clock (clk); reset rstc is synchronous and active-high.
- Reset values: acc=0, sample count=0, avg_out=0, avg_valid=0, state=COOL, confirm cnt=0, led=2'b10, alarm=0.
- Accumulator width is W+AVG_LOG2 and never overflows.
- Each accepted sample adds to acc and increments the sample count.
- On the edge accepting sample number 2^AVG_LOG2:
  - avg_out <= (acc+sample_in)>>AVG_LOG2 (truncating).
  - avg_valid <= 1 for exactly one cycle.
  - acc and count clear.
- No backpressure: sample_valid high in the same cycle as avg_valid is accepted as the first sample of the next block.
- Gaps between strobes are allowed and have no effect.
- Evidence: hot_ev = avg_out > TH_HI; cool_ev = avg_out < TH_HI-HYST. Both compares are strict and unsigned.
- The FSM evaluates only in cycles where avg_valid=1. The state, cnt, led and alarm update on that edge, so led reflects the average one cycle after avg_valid.
- FSM states: COOL=0, TO_HOT=1, HOT=2, TO_COOL=3.
  - COOL: hot_ev -> cnt=1. If CONFIRM==1 go to HOT, else go to TO_HOT. No hot_ev -> stay, cnt=0.
  - TO_HOT: hot_ev -> cnt+1. When cnt+1==CONFIRM go to HOT, cnt=0. No hot_ev -> COOL, cnt=0.
  - HOT: cool_ev -> cnt=1. If CONFIRM==1 go to COOL, else go to TO_COOL. No cool_ev -> stay.
  - TO_COOL: cool_ev -> cnt+1. When cnt+1==CONFIRM go to COOL, cnt=0. No cool_ev -> HOT, cnt=0.
- Outputs per state:
  - led=2'b01 and alarm=1 in HOT and TO_COOL.
  - led=2'b10 and alarm=0 in COOL and TO_HOT.
  - Pending states never change led.
- Band boundaries: avg==TH_HI is not hot evidence; avg==TH_HI-HYST is not cool evidence; an average inside the band breaks a pending transition.
- Reset mid-block discards the partial accumulation. Reset in a pending state returns to COOL with cnt=0.
- rstc wins over sample_valid in the same cycle.

Decomposition:
- Shared package temp_pkg:
  - ADC_W=10.
  - Default TH_HI=37, HYST=2, CONFIRM=3.
  - 2-bit state typedef with COOL/TO_HOT/HOT/TO_COOL encodings.
  - LED_HOT=2'b01, LED_COOL=2'b10.
- One sub-module, temp_avg: accumulator, sample counter, avg_out/avg_valid generation. The FSM, confirmation counter and LED/alarm logic stay in temp_alarm.

Test Plan:
- rstc high 2 cycles, no samples -> led=2'b10, alarm=0, avg_valid=0, avg_out=0, state_o=0.
- Samples 36,38,40,42 with 1-cycle gaps -> single avg_valid pulse one cycle after the edge accepting 42, with avg_out=39; state_o=1 on the next cycle.
- Three blocks each averaging 40 -> led stays 2'b10 after blocks 1-2; led=2'b01 and alarm=1 one cycle after the third avg_valid.
- From HOT:
  - Three blocks averaging 35 -> stays HOT (35 not < 35).
  - Then three blocks averaging 34 -> led=2'b10 after the third.
- From COOL, averages 40, 40, 37, 40, 40 -> never HOT; state_o sequence 1,1,0,1,1.
- rstc pulsed after 2 of 4 samples of value 500, then four samples of 100 -> avg_out=100 exactly (partial block discarded); sample_valid held high with rstc is ignored.
